tx_arbiter: RTL

// Two-requester, round-robin frame scheduler that shares the single RMII transmit

---
 rtl/tx_arbiter_if.sv | 31 +++
 rtl/tx_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tx_arbiter_if.sv
// Shared transmit-path bundle between two frame sources and the round-robin arbiter.
// The master side is the frame sources, the slave side is tx_arbiter.
interface tx_arbiter_if;
    logic       a_req;
    logic       a_axiiv;
    logic [1:0] a_axiid;
    logic       a_grant;
    logic       b_req;
    logic       b_axiiv;
    logic [1:0] b_axiid;
    logic       b_grant;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic       timeout;
    logic       truncated;

    modport master (
        output a_req, a_axiiv, a_axiid,
        output b_req, b_axiiv, b_axiid,
        input  a_grant, b_grant,
        input  axiov, axiod, busy, timeout, truncated
    );

    modport slave (
        input  a_req, a_axiiv, a_axiid,
        input  b_req, b_axiiv, b_axiid,
        output a_grant, b_grant,
        output axiov, axiod, busy, timeout, truncated
    );
endinterface

// File: rtl/tx_arbiter.sv
// Two-source round-robin frame scheduler for the RMII transmit path: one grant at a time,
// one-cycle dibit forwarding, start timeout, frame-length truncation and an idle gap.
module tx_arbiter #(
    parameter int unsigned GAP_CYCLES    = 160,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned MAX_DIBITS    = 3000
) (
    input logic         clk,
    input logic         rst,
    tx_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIBITS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        STREAM,
        DRAIN,
        GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic             r_last_b;
    logic             r_a_grant;
    logic             r_b_grant;
    logic             r_axiov;
    logic [1:0]       r_axiod;
    logic             r_busy;
    logic             r_timeout;
    logic             r_truncated;

    logic             w_v;
    logic [1:0]       w_d;
    logic             w_any;
    logic             w_pick_b;

    // Only the selected source is ever looked at; the other one is ignored entirely.
    assign w_v      = r_sel ? bus.b_axiiv : bus.a_axiiv;
    assign w_d      = r_sel ? bus.b_axiid : bus.a_axiid;
    assign w_any    = bus.a_req | bus.b_req;
    assign w_pick_b = bus.b_req & (~bus.a_req | ~r_last_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_last_b    <= 1'b1;
            r_a_grant   <= 1'b0;
            r_b_grant   <= 1'b0;
            r_axiov     <= 1'b0;
            r_axiod     <= 2'b00;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_truncated <= 1'b0;
        end else begin
            r_timeout   <= 1'b0;
            r_truncated <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel     <= w_pick_b;
                        r_a_grant <= ~w_pick_b;
                        r_b_grant <= w_pick_b;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (w_v) begin
                        r_axiov <= 1'b1;
                        r_axiod <= w_d;
                        r_cnt   <= CNT_W'(1);
                        r_state <= STREAM;
                    end else if (r_cnt == TMO_LAST) begin
                        // Nothing was sent, so the path is free again without a gap.
                        r_a_grant <= 1'b0;
                        r_b_grant <= 1'b0;
                        r_timeout <= 1'b1;
                        r_last_b  <= r_sel;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STREAM: begin
                    if (!w_v) begin
                        r_axiov   <= 1'b0;
                        r_axiod   <= 2'b00;
                        r_a_grant <= 1'b0;
                        r_b_grant <= 1'b0;
                        r_last_b  <= r_sel;
                        r_cnt     <= '0;
                        r_state   <= GAP;
                    end else if (r_cnt < MAX_CNT) begin
                        r_axiov <= 1'b1;
                        r_axiod <= w_d;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else begin
                        r_axiov     <= 1'b0;
                        r_axiod     <= 2'b00;
                        r_a_grant   <= 1'b0;
                        r_b_grant   <= 1'b0;
                        r_truncated <= 1'b1;
                        r_last_b    <= r_sel;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Swallow the rest of the over-long frame; the gap starts at its end.
                    if (!w_v) begin
                        r_cnt   <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_grant   = r_a_grant;
    assign bus.b_grant   = r_b_grant;
    assign bus.axiov     = r_axiov;
    assign bus.axiod     = r_axiod;
    assign bus.busy      = r_busy;
    assign bus.timeout   = r_timeout;
    assign bus.truncated = r_truncated;
endmodule
